// File: rtl/mips_defs_pkg.sv
// Shared definitions for the multi-cycle MIPS-32 control path: opcodes,
// ALU/mux encodings, the controller state enum and the control-word layout.
package mips_defs_pkg;

    localparam int OPCODE_W = 6;
    localparam int STATE_W  = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_RT     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

    // True for the opcodes this controller knows how to sequence.
    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_checker.sv
// Run-time checks on the controller outputs: exclusive memory and PC
// enables, and pulses confined to the states that may raise them.
module multicycle_ctrl_checker (
    input logic       clk,
    input logic       reset,
    input logic [3:0] state,
    input logic       pc_write,
    input logic       pc_write_cond,
    input logic       mem_read,
    input logic       mem_write,
    input logic       illegal_op,
    input logic       instr_done
);

    a_mem_excl: assert property (@(posedge clk) disable iff (reset)
        !(mem_read && mem_write));

    a_pc_excl: assert property (@(posedge clk) disable iff (reset)
        !(pc_write && pc_write_cond));

    a_illegal_in_decode: assert property (@(posedge clk) disable iff (reset)
        illegal_op |-> (state == 4'd2));

    a_done_in_final: assert property (@(posedge clk) disable iff (reset)
        instr_done |-> (state inside {4'd5, 4'd6, 4'd8, 4'd9, 4'd11, 4'd12}));

endmodule

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state-to-control-word decoder; mem_ready and opcode only
// qualify the handshake-dependent and illegal-opcode bits.
module multicycle_ctrl_decode
    import mips_defs_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Decode the current state into datapath controls; unlisted bits stay 0.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUSRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.pc_write  = mem_ready;
                ctrl.ir_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = ALUSRCB_IMM_SH;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = ~is_legal_op(opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUSRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_32.sv
// Main control FSM for the multi-cycle MIPS-32 datapath: holds the state
// register and sequencing; control bits come from the state decoder.
module multicycle_control_32
    import mips_defs_pkg::*;
#(
    parameter int OPW = OPCODE_W,
    parameter int STW = STATE_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic [1:0]     PCSource,
    output logic           illegal_op,
    output logic           instr_done,
    output logic [STW-1:0] state
);

    state_t state_r;
    ctrl_t  ctrl_s;

    // State register with synchronous reset and per-state sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_RST;
        end else begin
            case (state_r)
                S_RST: state_r <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) state_r <= S_DECODE;
                    else           state_r <= S_FETCH;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     state_r <= S_EXEC;
                        OP_LW, OP_SW: state_r <= S_MEMADR;
                        OP_BEQ:       state_r <= S_BRANCH;
                        OP_ADDI:      state_r <= S_ADDIEX;
                        OP_J:         state_r <= S_JUMP;
                        default:      state_r <= S_FETCH;
                    endcase
                end
                // The instruction register holds opcode stable through MEMADR.
                S_MEMADR: begin
                    if (opcode == OP_SW) state_r <= S_MEMWR;
                    else                 state_r <= S_MEMRD;
                end
                S_MEMRD: begin
                    if (mem_ready) state_r <= S_MEMWB;
                    else           state_r <= S_MEMRD;
                end
                S_MEMWR: begin
                    if (mem_ready) state_r <= S_FETCH;
                    else           state_r <= S_MEMWR;
                end
                S_EXEC:   state_r <= S_ALUWB;
                S_ADDIEX: state_r <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_r <= S_FETCH;
                default:  state_r <= S_FETCH;
            endcase
        end
    end

    multicycle_ctrl_decode u_decode (
        .state     (state_r),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_s)
    );

    assign PCWrite     = ctrl_s.pc_write;
    assign PCWriteCond = ctrl_s.pc_write_cond;
    assign IorD        = ctrl_s.iord;
    assign MemRead     = ctrl_s.mem_read;
    assign MemWrite    = ctrl_s.mem_write;
    assign IRWrite     = ctrl_s.ir_write;
    assign MemtoReg    = ctrl_s.mem_to_reg;
    assign RegDst      = ctrl_s.reg_dst;
    assign RegWrite    = ctrl_s.reg_write;
    assign ALUSrcA     = ctrl_s.alu_src_a;
    assign ALUSrcB     = ctrl_s.alu_src_b;
    assign ALUOp       = ctrl_s.alu_op;
    assign PCSource    = ctrl_s.pc_source;
    assign illegal_op  = ctrl_s.illegal_op;
    assign instr_done  = ctrl_s.instr_done;
    assign state       = STW'(state_r);

    multicycle_ctrl_checker u_checker (
        .clk           (clk),
        .reset         (reset),
        .state         (state),
        .pc_write      (PCWrite),
        .pc_write_cond (PCWriteCond),
        .mem_read      (MemRead),
        .mem_write     (MemWrite),
        .illegal_op    (illegal_op),
        .instr_done    (instr_done)
    );

endmodule

// File: tb/tb_multicycle_control_32.sv
// Directed bench for multicycle_control_32: an instruction-level model
// expands each instruction into its expected per-cycle state and outputs.
module tb_multicycle_control_32;

    logic       clk = 1'b0;
    logic       reset, mem_ready;
    logic [5:0] opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op, instr_done;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic [17:0] outs;

    always #5 clk = ~clk;

    multicycle_control_32 dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op),
        .instr_done(instr_done), .state(state)
    );

    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                   PCSource, illegal_op, instr_done};

    int         errors = 0;
    int         checks = 0;
    int         q_state[$];
    bit         q_rdy[$];
    bit         q_rst[$];
    logic [5:0] q_op[$];
    logic [3:0] exp_state;
    logic [17:0] exp_outs;
    bit         chk_en = 1'b0;

    int         lat_q[$];
    int         lat_cnt = 0;
    bit         lat_valid = 1'b0;
    logic [3:0] prev_st = 4'hF;
    int         lat_exp[9] = '{4, 10, 4, 3, 4, 3, 2, 6, 5};

    // Expected control outputs for a state number, straight from the state table.
    function automatic logic [17:0] exp_vec(input int st, input bit rdy, input logic [5:0] op);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, il, dn;
        logic [1:0] sb, aop, ps;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, il, dn} = 12'b0;
        sb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            1:  begin mr = 1'b1; sb = 2'b01; pcw = rdy; irw = rdy; end
            2:  begin sb = 2'b11;
                      il = !(op inside {6'b000000, 6'b100011, 6'b101011,
                                        6'b000100, 6'b001000, 6'b000010}); end
            3:  begin sa = 1'b1; sb = 2'b10; end
            4:  begin mr = 1'b1; iord = 1'b1; end
            5:  begin rw = 1'b1; m2r = 1'b1; dn = 1'b1; end
            6:  begin mw = 1'b1; iord = 1'b1; dn = rdy; end
            7:  begin sa = 1'b1; aop = 2'b10; end
            8:  begin rw = 1'b1; rd = 1'b1; dn = 1'b1; end
            9:  begin sa = 1'b1; aop = 2'b01; pcwc = 1'b1; ps = 2'b01; dn = 1'b1; end
            10: begin sa = 1'b1; sb = 2'b10; end
            11: begin rw = 1'b1; dn = 1'b1; end
            12: begin pcw = 1'b1; ps = 2'b10; dn = 1'b1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, il, dn};
    endfunction

    task automatic push(input int st, input bit rdy, input bit rs, input logic [5:0] op);
        q_state.push_back(st);
        q_rdy.push_back(rdy);
        q_rst.push_back(rs);
        q_op.push_back(op);
    endtask

    // One instruction: fs fetch stalls, ms memory stalls, optional reset inside MEMRD.
    task automatic add_instr(input logic [5:0] op, input int fs, input int ms, input bit rst_mid);
        for (int k = 0; k < fs; k++) push(1, 1'b0, 1'b0, op);
        push(1, 1'b1, 1'b0, op);
        push(2, 1'b1, 1'b0, op);
        case (op)
            6'b000000: begin push(7, 1'b1, 1'b0, op); push(8, 1'b1, 1'b0, op); end
            6'b100011: begin
                push(3, 1'b1, 1'b0, op);
                if (rst_mid) begin
                    push(4, 1'b0, 1'b1, op);
                    push(0, 1'b0, 1'b0, op);
                end else begin
                    for (int k = 0; k < ms; k++) push(4, 1'b0, 1'b0, op);
                    push(4, 1'b1, 1'b0, op);
                    push(5, 1'b1, 1'b0, op);
                end
            end
            6'b101011: begin
                push(3, 1'b1, 1'b0, op);
                for (int k = 0; k < ms; k++) push(6, 1'b0, 1'b0, op);
                push(6, 1'b1, 1'b0, op);
            end
            6'b000100: push(9, 1'b1, 1'b0, op);
            6'b001000: begin push(10, 1'b1, 1'b0, op); push(11, 1'b1, 1'b0, op); end
            6'b000010: push(12, 1'b1, 1'b0, op);
            default: ;
        endcase
    endtask

    // Per-cycle comparison at mid-cycle, plus FETCH-to-FETCH latency tracking.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (state !== exp_state)
                $display("FAIL state: got %0d want %0d at %0t", state, exp_state, $time);
            if (state !== exp_state) errors++;
            checks++;
            if (outs !== exp_outs) begin
                errors++;
                $display("FAIL outputs(st=%0d): got %b want %b at %0t", exp_state, outs, exp_outs, $time);
            end
            checks++;
            if ((MemRead && MemWrite) || (PCWrite && PCWriteCond)) begin
                errors++;
                $display("FAIL exclusive_enables: got MR=%b MW=%b PW=%b PWC=%b want no pair both 1",
                         MemRead, MemWrite, PCWrite, PCWriteCond);
            end
            if (exp_state == 4'd9) begin
                checks++;
                if (!(ALUOp == 2'b01 && PCWriteCond && PCSource == 2'b01)) begin
                    errors++;
                    $display("FAIL beq_controls: got ALUOp=%b PWC=%b PCSource=%b want 01 1 01",
                             ALUOp, PCWriteCond, PCSource);
                end
            end
            if (exp_state == 4'd12) begin
                checks++;
                if (!(PCWrite && PCSource == 2'b10)) begin
                    errors++;
                    $display("FAIL jump_controls: got PCWrite=%b PCSource=%b want 1 10", PCWrite, PCSource);
                end
            end
            if (state == 4'd0) begin
                lat_valid = 1'b0;
            end else if (state == 4'd1 && prev_st != 4'd1) begin
                if (lat_valid) lat_q.push_back(lat_cnt);
                lat_valid = 1'b1;
                lat_cnt = 1;
            end else begin
                lat_cnt++;
            end
            prev_st = state;
        end
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b0; opcode = 6'b000000;
        push(0, 1'b0, 1'b1, 6'b000000);
        push(0, 1'b0, 1'b1, 6'b000000);
        push(0, 1'b0, 1'b0, 6'b000000);
        add_instr(6'b000000, 0, 0, 1'b0);
        add_instr(6'b100011, 2, 3, 1'b0);
        add_instr(6'b101011, 0, 0, 1'b0);
        add_instr(6'b000100, 0, 0, 1'b0);
        add_instr(6'b001000, 0, 0, 1'b0);
        add_instr(6'b000010, 0, 0, 1'b0);
        add_instr(6'b111111, 0, 0, 1'b0);
        add_instr(6'b101011, 0, 2, 1'b0);
        add_instr(6'b000000, 1, 0, 1'b0);
        add_instr(6'b100011, 0, 0, 1'b1);
        push(1, 1'b0, 1'b0, 6'b000000);

        for (int i = 0; i < q_state.size(); i++) begin
            @(posedge clk);
            #1;
            reset     = q_rst[i];
            mem_ready = q_rdy[i];
            opcode    = q_op[i];
            exp_state = 4'(q_state[i]);
            exp_outs  = exp_vec(q_state[i], q_rdy[i], q_op[i]);
            chk_en    = 1'b1;
        end
        @(posedge clk);
        #1;
        chk_en = 1'b0;

        checks++;
        if (lat_q.size() != 9) begin
            errors++;
            $display("FAIL latency_count: got %0d want 9", lat_q.size());
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i >= lat_q.size()) begin
                errors++;
                $display("FAIL latency[%0d]: got none want %0d", i, lat_exp[i]);
            end else if (lat_q[i] != lat_exp[i]) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d want %0d", i, lat_q[i], lat_exp[i]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
